// File: rtl/amber_regfile_pkg.sv
// amber_regfile_pkg
// Purpose: shared sizes for the register file and its scoreboard.
//   SIZE_DATA    GP register width
//   SIZE_ADDR    SR / AR register width
//   SIZE_TGT_*   register index widths per bank
//   SB_CNT_W     scoreboard counter width (max in-flight writes = 2**SB_CNT_W-1)
package amber_regfile_pkg;
  localparam int SIZE_DATA   = 24;
  localparam int SIZE_ADDR   = 16;
  localparam int SIZE_TGT_GP = 3;
  localparam int SIZE_TGT_SR = 2;
  localparam int SIZE_TGT_AR = 2;
  localparam int SB_CNT_W    = 3;
endpackage

// File: rtl/amber_regfile_sb.sv
// amber_regfile_sb
// Purpose: pending-write scoreboard for one register bank. One saturating
// counter per register: issue increments, retire decrements, flush clears.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_issue_we / i_issue_addr      decode issued a write to this register
//   i_retire_we / i_retire_addr    writeback retired a write to this register
//   i_flush                        clear all counts
//   i_query_addr                   NQ packed query indices (query 0 in the LSBs)
//   o_busy                         per query: a write is still pending
//   o_error                        sticky: saturation or underflow seen
module amber_regfile_sb #(
  parameter int AW    = 3,
  parameter int CNT_W = 3,
  parameter int NQ    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_issue_we,
  input  logic [AW-1:0]     i_issue_addr,
  input  logic              i_retire_we,
  input  logic [AW-1:0]     i_retire_addr,
  input  logic              i_flush,
  input  logic [NQ*AW-1:0]  i_query_addr,
  output logic [NQ-1:0]     o_busy,
  output logic              o_error
);
  localparam int              DEPTH   = 1 << AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [DEPTH];
  logic             r_flush_d;
  logic             r_error;
  logic [DEPTH-1:0] w_inc;
  logic [DEPTH-1:0] w_dec;

  // An issue in a flush cycle is dropped: the flush wins.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_inc[i] = i_issue_we && !i_flush && (i_issue_addr == AW'(i));
      w_dec[i] = i_retire_we && (i_retire_addr == AW'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= '0;
      r_flush_d <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_flush_d <= i_flush;
      for (int i = 0; i < DEPTH; i++) begin
        if (i_flush) begin
          r_cnt[i] <= '0;
        end else if (w_inc[i] && !w_dec[i]) begin
          if (r_cnt[i] == CNT_MAX) r_error <= 1'b1;
          else                     r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else if (w_dec[i] && !w_inc[i]) begin
          // Writebacks squashed by a flush may still arrive one cycle later;
          // those hit an empty counter without flagging an error.
          if (r_cnt[i] == '0) begin
            if (!r_flush_d) r_error <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  // A retiring write is subtracted so its register reads as free this cycle.
  for (genvar q = 0; q < NQ; q++) begin : g_query
    logic [AW-1:0] w_qaddr;
    logic          w_hit;
    assign w_qaddr   = i_query_addr[q*AW +: AW];
    assign w_hit     = i_retire_we && (i_retire_addr == w_qaddr);
    assign o_busy[q] = (r_cnt[w_qaddr] - CNT_W'(w_hit)) != '0;
  end

  assign o_error = r_error;
endmodule

// File: rtl/amber_regfile.sv
// amber_regfile
// Purpose: GP / SR / AR architectural register banks written by writeback,
// with combinational bypassed read ports for decode and a pending-write
// scoreboard per bank feeding the hazard unit.
// Ports:
//   iw_clk, iw_rst_n                       clock, asynchronous active-low reset
//   iw_{gp,sr,ar}_write_{enable,addr,data} writeback write ports
//   iw_gp_read_addr_{a,b} / ow_gp_read_data_{a,b} / ow_gp_busy_{a,b}
//   iw_sr_read_addr / ow_sr_read_data / ow_sr_busy
//   iw_ar_read_addr / ow_ar_read_data / ow_ar_busy
//   iw_issue_{gp,sr,ar}_{we,addr}          decode issue into the scoreboard
//   iw_flush                               clears all scoreboard counts
//   ow_sb_error                            sticky scoreboard error
module amber_regfile
  import amber_regfile_pkg::*;
#(
  parameter int DATA_W = SIZE_DATA,
  parameter int ADDR_W = SIZE_ADDR,
  parameter int GP_AW  = SIZE_TGT_GP,
  parameter int SR_AW  = SIZE_TGT_SR,
  parameter int AR_AW  = SIZE_TGT_AR,
  parameter int CNT_W  = SB_CNT_W
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_gp_write_enable,
  input  logic [GP_AW-1:0]  iw_gp_write_addr,
  input  logic [DATA_W-1:0] iw_gp_write_data,
  input  logic              iw_sr_write_enable,
  input  logic [SR_AW-1:0]  iw_sr_write_addr,
  input  logic [ADDR_W-1:0] iw_sr_write_data,
  input  logic              iw_ar_write_enable,
  input  logic [AR_AW-1:0]  iw_ar_write_addr,
  input  logic [ADDR_W-1:0] iw_ar_write_data,
  input  logic [GP_AW-1:0]  iw_gp_read_addr_a,
  input  logic [GP_AW-1:0]  iw_gp_read_addr_b,
  output logic [DATA_W-1:0] ow_gp_read_data_a,
  output logic [DATA_W-1:0] ow_gp_read_data_b,
  output logic              ow_gp_busy_a,
  output logic              ow_gp_busy_b,
  input  logic [SR_AW-1:0]  iw_sr_read_addr,
  output logic [ADDR_W-1:0] ow_sr_read_data,
  output logic              ow_sr_busy,
  input  logic [AR_AW-1:0]  iw_ar_read_addr,
  output logic [ADDR_W-1:0] ow_ar_read_data,
  output logic              ow_ar_busy,
  input  logic              iw_issue_gp_we,
  input  logic [GP_AW-1:0]  iw_issue_gp_addr,
  input  logic              iw_issue_sr_we,
  input  logic [SR_AW-1:0]  iw_issue_sr_addr,
  input  logic              iw_issue_ar_we,
  input  logic [AR_AW-1:0]  iw_issue_ar_addr,
  input  logic              iw_flush,
  output logic              ow_sb_error
);
  localparam int GP_DEPTH = 1 << GP_AW;
  localparam int SR_DEPTH = 1 << SR_AW;
  localparam int AR_DEPTH = 1 << AR_AW;

  logic [DATA_W-1:0] r_gp [GP_DEPTH];
  logic [ADDR_W-1:0] r_sr [SR_DEPTH];
  logic [ADDR_W-1:0] r_ar [AR_DEPTH];

  logic [1:0] w_gp_busy;
  logic       w_sr_busy;
  logic       w_ar_busy;
  logic       w_gp_err;
  logic       w_sr_err;
  logic       w_ar_err;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int i = 0; i < GP_DEPTH; i++) r_gp[i] <= '0;
      for (int i = 0; i < SR_DEPTH; i++) r_sr[i] <= '0;
      for (int i = 0; i < AR_DEPTH; i++) r_ar[i] <= '0;
    end else begin
      if (iw_gp_write_enable) r_gp[iw_gp_write_addr] <= iw_gp_write_data;
      if (iw_sr_write_enable) r_sr[iw_sr_write_addr] <= iw_sr_write_data;
      if (iw_ar_write_enable) r_ar[iw_ar_write_addr] <= iw_ar_write_data;
    end
  end

  // Same-cycle write bypass on every read port.
  assign ow_gp_read_data_a = (iw_gp_write_enable && iw_gp_write_addr == iw_gp_read_addr_a)
                             ? iw_gp_write_data : r_gp[iw_gp_read_addr_a];
  assign ow_gp_read_data_b = (iw_gp_write_enable && iw_gp_write_addr == iw_gp_read_addr_b)
                             ? iw_gp_write_data : r_gp[iw_gp_read_addr_b];
  assign ow_sr_read_data   = (iw_sr_write_enable && iw_sr_write_addr == iw_sr_read_addr)
                             ? iw_sr_write_data : r_sr[iw_sr_read_addr];
  assign ow_ar_read_data   = (iw_ar_write_enable && iw_ar_write_addr == iw_ar_read_addr)
                             ? iw_ar_write_data : r_ar[iw_ar_read_addr];

  amber_regfile_sb #(.AW(GP_AW), .CNT_W(CNT_W), .NQ(2)) u_sb_gp (
    .i_clk         (iw_clk),
    .i_rst_n       (iw_rst_n),
    .i_issue_we    (iw_issue_gp_we),
    .i_issue_addr  (iw_issue_gp_addr),
    .i_retire_we   (iw_gp_write_enable),
    .i_retire_addr (iw_gp_write_addr),
    .i_flush       (iw_flush),
    .i_query_addr  ({iw_gp_read_addr_b, iw_gp_read_addr_a}),
    .o_busy        (w_gp_busy),
    .o_error       (w_gp_err)
  );

  amber_regfile_sb #(.AW(SR_AW), .CNT_W(CNT_W), .NQ(1)) u_sb_sr (
    .i_clk         (iw_clk),
    .i_rst_n       (iw_rst_n),
    .i_issue_we    (iw_issue_sr_we),
    .i_issue_addr  (iw_issue_sr_addr),
    .i_retire_we   (iw_sr_write_enable),
    .i_retire_addr (iw_sr_write_addr),
    .i_flush       (iw_flush),
    .i_query_addr  (iw_sr_read_addr),
    .o_busy        (w_sr_busy),
    .o_error       (w_sr_err)
  );

  amber_regfile_sb #(.AW(AR_AW), .CNT_W(CNT_W), .NQ(1)) u_sb_ar (
    .i_clk         (iw_clk),
    .i_rst_n       (iw_rst_n),
    .i_issue_we    (iw_issue_ar_we),
    .i_issue_addr  (iw_issue_ar_addr),
    .i_retire_we   (iw_ar_write_enable),
    .i_retire_addr (iw_ar_write_addr),
    .i_flush       (iw_flush),
    .i_query_addr  (iw_ar_read_addr),
    .o_busy        (w_ar_busy),
    .o_error       (w_ar_err)
  );

  assign ow_gp_busy_a = w_gp_busy[0];
  assign ow_gp_busy_b = w_gp_busy[1];
  assign ow_sr_busy   = w_sr_busy;
  assign ow_ar_busy   = w_ar_busy;
  assign ow_sb_error  = w_gp_err | w_sr_err | w_ar_err;
endmodule

// File: tb/tb_amber_regfile.sv
// tb_amber_regfile
// Purpose: self-checking bench for amber_regfile. Directed vector table for
// the GP path, hand sequences for multi-cycle corner cases, then randomized
// traffic against a behavioural model of banks and pending-write counts.
module tb_amber_regfile;
  import amber_regfile_pkg::*;

  localparam int DW   = SIZE_DATA;
  localparam int AWD  = SIZE_ADDR;
  localparam int GAW  = SIZE_TGT_GP;
  localparam int SAW  = SIZE_TGT_SR;
  localparam int AAW  = SIZE_TGT_AR;
  localparam int CMAX = (1 << SB_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Stimulus per bank: 0 = GP, 1 = SR, 2 = AR
  logic        bwe [3];
  logic [2:0]  bwa [3];
  logic [23:0] bwd [3];
  logic        bie [3];
  logic [2:0]  bia [3];
  logic        flush;
  logic [2:0]  ra_ga, ra_gb, ra_sr, ra_ar;

  logic [DW-1:0]  gp_a, gp_b;
  logic [AWD-1:0] sr_d, ar_d;
  logic gp_busy_a, gp_busy_b, sr_busy, ar_busy, sb_err;

  amber_regfile dut (
    .iw_clk             (clk),
    .iw_rst_n           (rst_n),
    .iw_gp_write_enable (bwe[0]),
    .iw_gp_write_addr   (bwa[0][GAW-1:0]),
    .iw_gp_write_data   (bwd[0][DW-1:0]),
    .iw_sr_write_enable (bwe[1]),
    .iw_sr_write_addr   (bwa[1][SAW-1:0]),
    .iw_sr_write_data   (bwd[1][AWD-1:0]),
    .iw_ar_write_enable (bwe[2]),
    .iw_ar_write_addr   (bwa[2][AAW-1:0]),
    .iw_ar_write_data   (bwd[2][AWD-1:0]),
    .iw_gp_read_addr_a  (ra_ga[GAW-1:0]),
    .iw_gp_read_addr_b  (ra_gb[GAW-1:0]),
    .ow_gp_read_data_a  (gp_a),
    .ow_gp_read_data_b  (gp_b),
    .ow_gp_busy_a       (gp_busy_a),
    .ow_gp_busy_b       (gp_busy_b),
    .iw_sr_read_addr    (ra_sr[SAW-1:0]),
    .ow_sr_read_data    (sr_d),
    .ow_sr_busy         (sr_busy),
    .iw_ar_read_addr    (ra_ar[AAW-1:0]),
    .ow_ar_read_data    (ar_d),
    .ow_ar_busy         (ar_busy),
    .iw_issue_gp_we     (bie[0]),
    .iw_issue_gp_addr   (bia[0][GAW-1:0]),
    .iw_issue_sr_we     (bie[1]),
    .iw_issue_sr_addr   (bia[1][SAW-1:0]),
    .iw_issue_ar_we     (bie[2]),
    .iw_issue_ar_addr   (bia[2][AAW-1:0]),
    .iw_flush           (flush),
    .ow_sb_error        (sb_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] m_mem [3][8];
  int          m_cnt [3][8];
  bit          m_err;
  bit          m_flush_prev;

  function automatic int depth(input int b);
    return (b == 0) ? (1 << GAW) : (b == 1) ? (1 << SAW) : (1 << AAW);
  endfunction

  function automatic logic [23:0] dmask(input int b);
    return (b == 0) ? 24'hFFFFFF : 24'h00FFFF;
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 8; r++) begin
        m_mem[b][r] = '0;
        m_cnt[b][r] = 0;
      end
    m_err = 0;
    m_flush_prev = 0;
  endfunction

  function automatic void model_step();
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < depth(b); r++) begin
        int delta;
        delta = 0;
        if (bie[b] && int'(bia[b]) == r && !flush) delta += 1;
        if (bwe[b] && int'(bwa[b]) == r) delta -= 1;
        if (flush) m_cnt[b][r] = 0;
        else if (delta > 0 && m_cnt[b][r] == CMAX) m_err = 1;
        else if (delta < 0 && m_cnt[b][r] == 0) begin
          if (!m_flush_prev) m_err = 1;
        end else m_cnt[b][r] += delta;
      end
      if (bwe[b]) m_mem[b][bwa[b]] = bwd[b] & dmask(b);
    end
    m_flush_prev = flush;
  endfunction

  function automatic logic [23:0] m_read(input int b, input logic [2:0] a);
    return (bwe[b] && bwa[b] == a) ? (bwd[b] & dmask(b)) : m_mem[b][a];
  endfunction

  function automatic logic m_busy(input int b, input logic [2:0] a);
    int pend;
    pend = m_cnt[b][a] - ((bwe[b] && bwa[b] == a) ? 1 : 0);
    return pend != 0;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, " gp_a"},   32'(gp_a),      32'(m_read(0, ra_ga)));
    chk({tag, " gp_b"},   32'(gp_b),      32'(m_read(0, ra_gb)));
    chk({tag, " sr"},     32'(sr_d),      32'(m_read(1, ra_sr)));
    chk({tag, " ar"},     32'(ar_d),      32'(m_read(2, ra_ar)));
    chk({tag, " busy_a"}, 32'(gp_busy_a), 32'(m_busy(0, ra_ga)));
    chk({tag, " busy_b"}, 32'(gp_busy_b), 32'(m_busy(0, ra_gb)));
    chk({tag, " sr_bsy"}, 32'(sr_busy),   32'(m_busy(1, ra_sr)));
    chk({tag, " ar_bsy"}, 32'(ar_busy),   32'(m_busy(2, ra_ar)));
    chk({tag, " err"},    32'(sb_err),    32'(m_err));
  endtask

  task automatic idle();
    for (int b = 0; b < 3; b++) begin
      bwe[b] = 0; bwa[b] = 0; bwd[b] = 0; bie[b] = 0; bia[b] = 0;
    end
    flush = 0;
    ra_ga = 0; ra_gb = 0; ra_sr = 0; ra_ar = 0;
  endtask

  // Inputs change 1 time unit after posedge; checks sit mid-cycle.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  typedef struct {
    bit gwe; logic [2:0] gwa; logic [23:0] gwd;
    bit gie; logic [2:0] gia; bit fl;
    logic [2:0] ra; logic [2:0] rb;
    logic [23:0] ea; logic [23:0] eb;
    bit cbusy; bit ebusy; bit eerr;
  } vec_t;

  vec_t tbl [17];

  initial begin
    //            gwe gwa  gwd          gie gia  fl  ra   rb   ea           eb           cb ebsy err
    tbl[0]  = '{1'b0, 3'd0, 24'h000000, 1'b1, 3'd5, 1'b0, 3'd5, 3'd5, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'd5, 24'h123456, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5, 24'h123456, 24'h123456, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 24'h000000, 1'b0, 3'd0, 1'b0, 3'd5, 3'd0, 24'h123456, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 24'h000000, 1'b1, 3'd5, 1'b0, 3'd5, 3'd0, 24'h123456, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 3'd5, 24'hABCDEF, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5, 24'hABCDEF, 24'hABCDEF, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 24'h000000, 1'b1, 3'd3, 1'b0, 3'd3, 3'd5, 24'h000000, 24'hABCDEF, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 24'h000000, 1'b1, 3'd3, 1'b0, 3'd3, 3'd5, 24'h000000, 24'hABCDEF, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 24'h000000, 1'b1, 3'd3, 1'b0, 3'd3, 3'd3, 24'h000000, 24'h000000, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 3'd3, 24'h000111, 1'b0, 3'd0, 1'b0, 3'd3, 3'd5, 24'h000111, 24'hABCDEF, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 3'd3, 24'h000222, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3, 24'h000222, 24'h000222, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 3'd3, 24'h000333, 1'b0, 3'd0, 1'b0, 3'd3, 3'd5, 24'h000333, 24'hABCDEF, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 3'd0, 24'h000000, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3, 24'h000333, 24'h000333, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 3'd0, 24'h000000, 1'b1, 3'd7, 1'b0, 3'd7, 3'd7, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 3'd0, 24'h000000, 1'b1, 3'd7, 1'b0, 3'd7, 3'd7, 24'h000000, 24'h000000, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 3'd0, 24'h000000, 1'b1, 3'd7, 1'b1, 3'd7, 3'd7, 24'h000000, 24'h000000, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 3'd7, 24'h0000AA, 1'b0, 3'd0, 1'b0, 3'd7, 3'd7, 24'h0000AA, 24'h0000AA, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 3'd0, 24'h000000, 1'b0, 3'd0, 1'b0, 3'd7, 3'd7, 24'h0000AA, 24'h0000AA, 1'b1, 1'b0, 1'b0};

    idle();
    model_reset();
    #2;
    chk("rst gp_a", 32'(gp_a), 32'h0);
    chk("rst busy_a", 32'(gp_busy_a), 32'h0);
    chk("rst err", 32'(sb_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // ---------------- GP vector table ----------------
    for (int i = 0; i < 17; i++) begin
      idle();
      bwe[0] = tbl[i].gwe; bwa[0] = tbl[i].gwa; bwd[0] = tbl[i].gwd;
      bie[0] = tbl[i].gie; bia[0] = tbl[i].gia; flush = tbl[i].fl;
      ra_ga = tbl[i].ra; ra_gb = tbl[i].rb;
      #4;
      chk($sformatf("vec%0d gp_a", i), 32'(gp_a), 32'(tbl[i].ea));
      chk($sformatf("vec%0d gp_b", i), 32'(gp_b), 32'(tbl[i].eb));
      if (tbl[i].cbusy) chk($sformatf("vec%0d busy_a", i), 32'(gp_busy_a), 32'(tbl[i].ebusy));
      chk($sformatf("vec%0d err", i), 32'(sb_err), 32'(tbl[i].eerr));
      tick();
    end

    // ---------------- AR: issue and retire together ----------------
    idle(); ra_ar = 1; bie[2] = 1; bia[2] = 1;
    #4; chk("ar pre busy", 32'(ar_busy), 32'h0);
    tick();
    idle(); ra_ar = 1; bie[2] = 1; bia[2] = 1; bwe[2] = 1; bwa[2] = 1; bwd[2] = 24'h005A5A;
    #4; chk("ar same busy", 32'(ar_busy), 32'h0);
    chk("ar same data", 32'(ar_d), 32'h5A5A);
    tick();
    idle(); ra_ar = 1;
    #4; chk("ar next busy", 32'(ar_busy), 32'h1);
    chk("ar next data", 32'(ar_d), 32'h5A5A);
    chk("ar err", 32'(sb_err), 32'h0);
    tick();
    idle(); ra_ar = 1; bwe[2] = 1; bwa[2] = 1; bwd[2] = 24'h005A5A;
    #4; chk("ar last busy", 32'(ar_busy), 32'h0);
    tick();

    // ---------------- SR: saturation ----------------
    for (int k = 0; k < 8; k++) begin
      idle(); ra_sr = 2; bie[1] = 1; bia[1] = 2;
      #4; chk($sformatf("sr sat%0d err", k), 32'(sb_err), 32'h0);
      tick();
    end
    idle(); ra_sr = 2;
    #4; chk("sr sat err", 32'(sb_err), 32'h1);
    chk("sr sat busy", 32'(sr_busy), 32'h1);
    tick();
    for (int k = 0; k < 7; k++) begin
      idle(); ra_sr = 2; bwe[1] = 1; bwa[1] = 2; bwd[1] = 24'(k + 1);
      #4; chk($sformatf("sr drain%0d busy", k), 32'(sr_busy), (k < 6) ? 32'h1 : 32'h0);
      tick();
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    idle(); bie[0] = 1; bia[0] = 1;
    tick();
    idle(); ra_ga = 5; ra_gb = 1; ra_sr = 2; ra_ar = 1;
    #2;
    chk("pre rst busy_b", 32'(gp_busy_b), 32'h1);
    chk("pre rst gp_a", 32'(gp_a), 32'hABCDEF);
    rst_n = 0;
    model_reset();
    #1;
    chk("async gp_a", 32'(gp_a), 32'h0);
    chk("async gp_b", 32'(gp_b), 32'h0);
    chk("async sr", 32'(sr_d), 32'h0);
    chk("async ar", 32'(ar_d), 32'h0);
    chk("async busy_b", 32'(gp_busy_b), 32'h0);
    chk("async err", 32'(sb_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // ---------------- GP0 underflow ----------------
    idle(); bwe[0] = 1; bwa[0] = 0; bwd[0] = 24'h000777;
    #4; chk("uf before", 32'(sb_err), 32'h0);
    tick();
    idle();
    #4; chk("uf after", 32'(sb_err), 32'h1);
    chk("uf data", 32'(gp_a), 32'h777);
    tick();

    // ---------------- randomized against model ----------------
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 149) do_reset();
      for (int b = 0; b < 3; b++) begin
        bie[b] = ($urandom_range(0, 2) == 0);
        bia[b] = 3'($urandom_range(0, depth(b) - 1));
        bwe[b] = ($urandom_range(0, 2) == 0);
        bwa[b] = 3'($urandom_range(0, depth(b) - 1));
        bwd[b] = 24'($urandom) & dmask(b);
      end
      flush = ($urandom_range(0, 19) == 0);
      ra_ga = 3'($urandom_range(0, depth(0) - 1));
      ra_gb = ($urandom_range(0, 3) == 0) ? ra_ga : 3'($urandom_range(0, depth(0) - 1));
      ra_sr = 3'($urandom_range(0, depth(1) - 1));
      ra_ar = 3'($urandom_range(0, depth(2) - 1));
      if ($urandom_range(0, 2) == 0) ra_ga = bwa[0];
      #4;
      compare_all($sformatf("rnd%0d", c));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
